gpr_wb_arbiter: RTL and testbench

GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

---
 rtl/gpr_pkg.sv | 16 +
 rtl/gpr_rr_arb.sv | 45 ++++
 rtl/gpr_wb_arbiter.sv | 84 ++++++++
 tb/tb_gpr_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared widths, register-zero constant and requester index encoding
package gpr_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   // Architectural zero register: writes to it are swallowed when dropping is enabled
   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   // Requester index, also the value held by the round-robin pointer
   typedef enum logic {
      REQ_EX  = 1'b0,
      REQ_MEM = 1'b1
   } req_idx_t;

endpackage

// File: rtl/gpr_rr_arb.sv
// rtl/gpr_rr_arb.sv - two-way round-robin arbiter for the GPR writeback port
module gpr_rr_arb
   import gpr_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_0,
   input  logic req_1,
   output logic gnt_0,
   output logic gnt_1
);

   // Index of the most recently granted requester
   req_idx_t ptr;

   // Lone requester wins; under contention the requester not recorded in ptr wins
   always_comb begin
      gnt_0 = 1'b0;
      gnt_1 = 1'b0;
      if (reset) begin
         if (req_0 && req_1) begin
            if (ptr == REQ_EX) begin
               gnt_1 = 1'b1;
            end else begin
               gnt_0 = 1'b1;
            end
         end else begin
            gnt_0 = req_0;
            gnt_1 = req_1;
         end
      end
   end

   // Pointer follows every grant; reset value makes EX win the first contention
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr <= REQ_MEM;
      end else if (gnt_0) begin
         ptr <= REQ_EX;
      end else if (gnt_1) begin
         ptr <= REQ_MEM;
      end
   end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - EX/MEM writeback arbiter with registered GPR write, bypass and conflict counter
module gpr_wb_arbiter #(
   parameter int DATA_W  = gpr_pkg::DATA_W,
   parameter int ADDR_W  = gpr_pkg::ADDR_W,
   parameter int DROP_R0 = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_0,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [DATA_W-1:0] data_0,
   output logic              gnt_0,
   input  logic              req_1,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] data_1,
   output logic              gnt_1,
   output logic              we_,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_0,
   input  logic [ADDR_W-1:0] rd_addr_1,
   output logic              fwd_hit_0,
   output logic [DATA_W-1:0] fwd_data_0,
   output logic              fwd_hit_1,
   output logic [DATA_W-1:0] fwd_data_1,
   output logic [15:0]       conf_cnt
);

   import gpr_pkg::*;

   logic              any_gnt;
   logic              drop;
   logic              issue;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   gpr_rr_arb u_arb (
      .clk   (clk),
      .reset (reset),
      .req_0 (req_0),
      .req_1 (req_1),
      .gnt_0 (gnt_0),
      .gnt_1 (gnt_1)
   );

   assign any_gnt  = gnt_0 | gnt_1;
   assign sel_addr = gnt_1 ? addr_1 : addr_0;
   assign sel_data = gnt_1 ? data_1 : data_0;
   assign drop     = (DROP_R0 != 0) && (sel_addr == ADDR_W'(REG_ZERO));
   assign issue    = any_gnt && !drop;

   // Register the granted write for one cycle; idle or dropped grants keep the last address/data
   always_ff @(posedge clk) begin
      if (!reset) begin
         we_     <= 1'b1;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         we_ <= !issue;
         if (issue) begin
            wr_addr <= sel_addr;
            wr_data <= sel_data;
         end
      end
   end

   // Count cycles where both requesters contend, saturating at all-ones
   always_ff @(posedge clk) begin
      if (!reset) begin
         conf_cnt <= '0;
      end else if (req_0 && req_1 && (conf_cnt != 16'hFFFF)) begin
         conf_cnt <= conf_cnt + 16'd1;
      end
   end

   // Bypass the in-flight write to any read port naming the same register
   always_comb begin
      fwd_hit_0  = !we_ && (rd_addr_0 == wr_addr);
      fwd_hit_1  = !we_ && (rd_addr_1 == wr_addr);
      fwd_data_0 = fwd_hit_0 ? wr_data : '0;
      fwd_data_1 = fwd_hit_1 ? wr_data : '0;
   end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - self-checking bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_0, req_1;
   logic [4:0]  addr_0, addr_1;
   logic [31:0] data_0, data_1;
   logic        gnt_0, gnt_1;
   logic        we_;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr_0, rd_addr_1;
   logic        fwd_hit_0, fwd_hit_1;
   logic [31:0] fwd_data_0, fwd_data_1;
   logic [15:0] conf_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   gpr_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_R0(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_0      (req_0),
      .addr_0     (addr_0),
      .data_0     (data_0),
      .gnt_0      (gnt_0),
      .req_1      (req_1),
      .addr_1     (addr_1),
      .data_1     (data_1),
      .gnt_1      (gnt_1),
      .we_        (we_),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr_0  (rd_addr_0),
      .rd_addr_1  (rd_addr_1),
      .fwd_hit_0  (fwd_hit_0),
      .fwd_data_0 (fwd_data_0),
      .fwd_hit_1  (fwd_hit_1),
      .fwd_data_1 (fwd_data_1),
      .conf_cnt   (conf_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
   endtask

   // Vector record: inputs for one cycle and the outputs expected before its edge
   typedef struct {
      bit          rst;
      bit          r0;
      logic [4:0]  a0;
      logic [31:0] d0;
      bit          r1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      bit          g0;
      bit          g1;
      bit          we;
      logic [4:0]  wa;
      logic [31:0] wd;
      bit          h0;
      logic [31:0] f0;
      bit          h1;
      logic [31:0] f1;
      logic [15:0] cnt;
   } vec_t;

   function automatic vec_t mk(bit rst, bit r0, logic [4:0] a0, logic [31:0] d0,
                               bit r1, logic [4:0] a1, logic [31:0] d1,
                               logic [4:0] ra0, logic [4:0] ra1,
                               bit g0, bit g1, bit we, logic [4:0] wa, logic [31:0] wd,
                               bit h0, logic [31:0] f0, bit h1, logic [31:0] f1,
                               logic [15:0] cnt);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1; v.d1 = d1;
      v.ra0 = ra0; v.ra1 = ra1; v.g0 = g0; v.g1 = g1; v.we = we; v.wa = wa; v.wd = wd;
      v.h0 = h0; v.f0 = f0; v.h1 = h1; v.f1 = f1; v.cnt = cnt;
      return v;
   endfunction

   vec_t tbl[18];

   // Reference model state: spec-level view of the pending GPR write
   int          m_last;
   bit          m_inflight;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_cnt;

   task automatic model_reset();
      m_last = 1; m_inflight = 0; m_addr = '0; m_data = '0; m_cnt = 0;
   endtask

   // One cycle against the model: check before the edge, advance the model at the edge
   task automatic model_step(output int g);
      logic [4:0]  a;
      logic [31:0] d;
      bit          both;
      if (!reset) g = -1;
      else if (req_0 && req_1) g = (m_last == 0) ? 1 : 0;
      else if (req_0) g = 0;
      else if (req_1) g = 1;
      else g = -1;
      both = req_0 && req_1;
      a = (g == 1) ? addr_1 : addr_0;
      d = (g == 1) ? data_1 : data_0;
      @(negedge clk);
      chk("rnd_gnt_0", gnt_0, g == 0);
      chk("rnd_gnt_1", gnt_1, g == 1);
      chk("rnd_we_", we_, !m_inflight);
      chk("rnd_wr_addr", wr_addr, m_addr);
      chk("rnd_wr_data", wr_data, m_data);
      chk("rnd_hit_0", fwd_hit_0, m_inflight && rd_addr_0 == m_addr);
      chk("rnd_hit_1", fwd_hit_1, m_inflight && rd_addr_1 == m_addr);
      chk("rnd_fwd_0", fwd_data_0, (m_inflight && rd_addr_0 == m_addr) ? m_data : 32'h0);
      chk("rnd_fwd_1", fwd_data_1, (m_inflight && rd_addr_1 == m_addr) ? m_data : 32'h0);
      chk("rnd_conf_cnt", conf_cnt, m_cnt[15:0]);
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else begin
         if (both) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (g >= 0) begin
            m_last = g;
            if (a == 5'd0) m_inflight = 0;
            else begin
               m_inflight = 1; m_addr = a; m_data = d;
            end
         end else begin
            m_inflight = 0;
         end
      end
      #1;
   endtask

   initial begin
      int g;
      bit p0, p1;

      tbl[0]  = mk(1, 0,0,0,                0,0,0,                0,0, 0,0,1,0,0,                0,0,0,0,0);
      tbl[1]  = mk(1, 1,3,32'hA5A5A5A5,     0,0,0,                3,0, 1,0,1,0,0,                0,0,0,0,0);
      tbl[2]  = mk(1, 0,0,0,                0,0,0,                3,4, 0,0,0,3,32'hA5A5A5A5,     1,32'hA5A5A5A5,0,0,0);
      tbl[3]  = mk(1, 0,0,0,                0,0,0,                3,3, 0,0,1,3,32'hA5A5A5A5,     0,0,0,0,0);
      tbl[4]  = mk(0, 1,1,32'h11111111,     1,2,32'h22222222,     0,0, 0,0,1,3,32'hA5A5A5A5,     0,0,0,0,0);
      tbl[5]  = mk(1, 1,1,32'h11111111,     1,2,32'h22222222,     1,2, 1,0,1,0,0,                0,0,0,0,0);
      tbl[6]  = mk(1, 1,1,32'h11111111,     1,2,32'h22222222,     1,2, 0,1,0,1,32'h11111111,     1,32'h11111111,0,0,1);
      tbl[7]  = mk(1, 1,1,32'h11111111,     1,2,32'h22222222,     1,2, 1,0,0,2,32'h22222222,     0,0,1,32'h22222222,2);
      tbl[8]  = mk(1, 1,1,32'h11111111,     1,2,32'h22222222,     0,0, 0,1,0,1,32'h11111111,     0,0,0,0,3);
      tbl[9]  = mk(1, 0,0,0,                0,0,0,                2,2, 0,0,0,2,32'h22222222,     1,32'h22222222,1,32'h22222222,4);
      tbl[10] = mk(1, 1,7,32'h12345678,     0,0,0,                0,0, 1,0,1,2,32'h22222222,     0,0,0,0,4);
      tbl[11] = mk(1, 0,0,0,                0,0,0,                7,8, 0,0,0,7,32'h12345678,     1,32'h12345678,0,0,4);
      tbl[12] = mk(1, 0,0,0,                1,0,32'hFFFFFFFF,     0,0, 0,1,1,7,32'h12345678,     0,0,0,0,4);
      tbl[13] = mk(1, 0,0,0,                0,0,0,                0,0, 0,0,1,7,32'h12345678,     0,0,0,0,4);
      tbl[14] = mk(1, 1,5,32'hAAAA0000,     1,5,32'hBBBB0000,     0,0, 1,0,1,7,32'h12345678,     0,0,0,0,4);
      tbl[15] = mk(1, 0,0,0,                1,5,32'hBBBB0000,     5,5, 0,1,0,5,32'hAAAA0000,     1,32'hAAAA0000,1,32'hAAAA0000,5);
      tbl[16] = mk(1, 0,0,0,                0,0,0,                5,6, 0,0,0,5,32'hBBBB0000,     1,32'hBBBB0000,0,0,5);
      tbl[17] = mk(1, 0,0,0,                0,0,0,                5,5, 0,0,1,5,32'hBBBB0000,     0,0,0,0,5);

      reset = 1'b0; req_0 = 0; req_1 = 0; addr_0 = 0; addr_1 = 0;
      data_0 = 0; data_1 = 0; rd_addr_0 = 0; rd_addr_1 = 0;
      repeat (2) @(posedge clk);
      #1;

      // Table-driven directed vectors
      for (int i = 0; i < 18; i++) begin
         reset = tbl[i].rst;
         req_0 = tbl[i].r0; addr_0 = tbl[i].a0; data_0 = tbl[i].d0;
         req_1 = tbl[i].r1; addr_1 = tbl[i].a1; data_1 = tbl[i].d1;
         rd_addr_0 = tbl[i].ra0; rd_addr_1 = tbl[i].ra1;
         @(negedge clk);
         chk($sformatf("v%0d_gnt_0", i), gnt_0, tbl[i].g0);
         chk($sformatf("v%0d_gnt_1", i), gnt_1, tbl[i].g1);
         chk($sformatf("v%0d_we_", i), we_, tbl[i].we);
         chk($sformatf("v%0d_wr_addr", i), wr_addr, tbl[i].wa);
         chk($sformatf("v%0d_wr_data", i), wr_data, tbl[i].wd);
         chk($sformatf("v%0d_hit_0", i), fwd_hit_0, tbl[i].h0);
         chk($sformatf("v%0d_fwd_0", i), fwd_data_0, tbl[i].f0);
         chk($sformatf("v%0d_hit_1", i), fwd_hit_1, tbl[i].h1);
         chk($sformatf("v%0d_fwd_1", i), fwd_data_1, tbl[i].f1);
         chk($sformatf("v%0d_conf_cnt", i), conf_cnt, tbl[i].cnt);
         @(posedge clk);
         #1;
      end

      // Reset mid-operation: grant at edge N, reset at edge N+1
      reset = 1; req_0 = 1; addr_0 = 9; data_0 = 32'hCAFEF00D; req_1 = 0;
      rd_addr_0 = 9; rd_addr_1 = 0;
      @(negedge clk);
      chk("mid_gnt_0_before", gnt_0, 1);
      @(posedge clk); #1;
      reset = 0; req_0 = 1; req_1 = 1; addr_1 = 10; data_1 = 32'h0BADBEEF;
      @(negedge clk);
      chk("mid_inflight_we_", we_, 0);
      chk("mid_inflight_hit_0", fwd_hit_0, 1);
      chk("mid_rst_gnt_0", gnt_0, 0);
      chk("mid_rst_gnt_1", gnt_1, 0);
      chk("mid_cnt_before", conf_cnt, 5);
      @(posedge clk); #1;
      reset = 1;
      @(negedge clk);
      chk("mid_after_we_", we_, 1);
      chk("mid_after_hit_0", fwd_hit_0, 0);
      chk("mid_after_cnt", conf_cnt, 0);
      chk("mid_first_gnt_0", gnt_0, 1);
      chk("mid_first_gnt_1", gnt_1, 0);
      @(posedge clk); #1;

      // Saturation: continuous contention well past 16 bits
      addr_0 = 1; addr_1 = 2;
      repeat (65540) @(posedge clk);
      #1;
      @(negedge clk);
      chk("sat_cnt", conf_cnt, 16'hFFFF);
      chk("sat_one_gnt", gnt_0 ^ gnt_1, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sat_hold_cnt", conf_cnt, 16'hFFFF);
      @(posedge clk); #1;

      // Randomized run against the reference model
      req_0 = 0; req_1 = 0; reset = 0;
      @(posedge clk); #1;
      model_reset();
      reset = 1;
      p0 = 0; p1 = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!p0 && ($urandom_range(0, 1) == 1)) begin
            p0 = 1; addr_0 = 5'($urandom_range(0, 7)); data_0 = $urandom;
         end else if (p0 && ($urandom_range(0, 15) == 0)) begin
            p0 = 0;
         end
         if (!p1 && ($urandom_range(0, 1) == 1)) begin
            p1 = 1; addr_1 = 5'($urandom_range(0, 7)); data_1 = $urandom;
         end else if (p1 && ($urandom_range(0, 15) == 0)) begin
            p1 = 0;
         end
         req_0 = p0; req_1 = p1;
         rd_addr_0 = 5'($urandom_range(0, 7));
         rd_addr_1 = 5'($urandom_range(0, 7));
         reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         model_step(g);
         if (g == 0) p0 = 0;
         if (g == 1) p1 = 0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
